// File: rtl/mem_initiator.sv
// mem_initiator: burst master that turns single read/write commands into
// per-beat accesses on a simple synchronous SRAM port (combinational read,
// write at posedge). Writes stream one beat per cycle; reads take one cycle
// to address the memory and at least one cycle to hand the beat off.
module mem_initiator #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16,
    parameter int LEN_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_SIZE-1:0] cmd_addr,
    input  logic [LEN_SIZE-1:0]  cmd_len,

    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [WORD_SIZE-1:0] wr_data,

    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [WORD_SIZE-1:0] rd_data,

    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 mem_we,
    output logic                 mem_oe,

    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_RWAIT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q;
    logic [ADDR_SIZE-1:0]   cur_addr_q;
    logic [LEN_SIZE-1:0]    remaining_q;   // beats left after the current one
    logic                   rd_valid_q;
    logic [WORD_SIZE-1:0]   rd_data_q;

    // Burst sequencer: command capture, beat counting, address stepping and
    // the read-data holding register. Address increment wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every branch reads the pre-edge register values.
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr_q  <= cmd_addr;
                        remaining_q <= cmd_len;
                        state_q     <= cmd_write ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    // The memory commits the beat on this same edge.
                    if (wr_valid) begin
                        if (remaining_q == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            remaining_q <= remaining_q - LEN_SIZE'(1);
                            cur_addr_q  <= cur_addr_q + ADDR_SIZE'(1);
                        end
                    end
                end
                S_READ: begin
                    // Memory output is valid while addressed; capture it once.
                    rd_data_q  <= mem_rdata;
                    rd_valid_q <= 1'b1;
                    state_q    <= S_RWAIT;
                end
                S_RWAIT: begin
                    if (rd_valid_q && rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (remaining_q == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            remaining_q <= remaining_q - LEN_SIZE'(1);
                            cur_addr_q  <= cur_addr_q + ADDR_SIZE'(1);
                            state_q     <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Port decode from the state register; only the write strobe and write
    // data pass straight through from the beat interface.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_oe    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_WRITE: begin
                wr_ready  = 1'b1;
                mem_we    = wr_valid;
                mem_addr  = cur_addr_q;
                mem_wdata = wr_data;
            end
            S_READ: begin
                mem_oe   = 1'b1;
                mem_addr = cur_addr_q;
            end
            S_RWAIT: begin
                mem_addr = cur_addr_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 16, address width; MAX_ADDR = 2^ADDR_SIZE-1.
REQ-003 SHALL have parameter LEN_SIZE, default 8, burst-length field width.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  clock, all state updates on rising edge
  rst  in  1  reset, asynchronous, active-high
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when both high at posedge
  cmd_write  in  1  1 = write burst, 0 = read burst
  cmd_addr  in  ADDR_SIZE  burst start address
  cmd_len  in  LEN_SIZE  beats minus one (0 -> 1 beat, 255 -> 256 beats)
  wr_valid  in  1  write beat offered
  wr_ready  out  1  write beat accepted when both high at posedge
  wr_data  in  WORD_SIZE  write beat data
  rd_valid  out  1  read beat available
  rd_ready  in  1  read beat consumed when both high at posedge
  rd_data  out  WORD_SIZE  read beat data
  mem_addr  out  ADDR_SIZE  to memory addr
  mem_wdata  out  WORD_SIZE  to memory data_in
  mem_rdata  in  WORD_SIZE  from memory data_out (combinational, valid while mem_oe=1 and mem_we=0)
  mem_we  out  1  to memory we (write at posedge)
  mem_oe  out  1  to memory oe
  busy  out  1  high in any state other than IDLE
  done  out  1  one-cycle pulse at burst completion

Function
REQ-005 SHALL implement FSM states IDLE, WRITE, READ, RWAIT, DONE.
REQ-006 IDLE: cmd_ready=1; on cmd_valid latch cur_addr=cmd_addr, remaining=cmd_len, go WRITE if cmd_write else READ.
REQ-007 cmd_ready SHALL be 0 outside IDLE; cmd_valid outside IDLE ignored.
REQ-008 WRITE: wr_ready=1, mem_addr=cur_addr, mem_wdata=wr_data, mem_we=wr_valid (combinational); memory writes at the same posedge as the wr handshake.
REQ-009 WRITE beat handshake: if remaining=0 go DONE, else remaining-1, cur_addr+1; no handshake -> stay, mem_we=0.
REQ-010 READ: mem_oe=1, mem_addr=cur_addr; at next posedge rd_data<=mem_rdata, rd_valid<=1, go RWAIT (exactly 1 cycle in READ).
REQ-011 RWAIT: mem_oe=0; rd_data/rd_valid held stable until rd_ready; on handshake rd_valid<=0, then DONE if remaining=0, else remaining-1, cur_addr+1, go READ.
REQ-012 Read throughput SHALL be one beat per 2 cycles when rd_ready held high; write throughput one beat per cycle.
REQ-013 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in DONE.
REQ-014 cur_addr SHALL wrap MAX_ADDR -> 0 without error.
REQ-015 mem_we and mem_oe SHALL never be 1 in the same cycle.
REQ-016 Outside WRITE: mem_we=0, wr_ready=0, mem_wdata=0; wr_valid ignored. Outside READ: mem_oe=0.
REQ-017 mem_addr SHALL equal cur_addr in WRITE/READ/RWAIT, 0 in IDLE/DONE.
REQ-018 rd_ready without rd_valid SHALL be ignored.

Reset
REQ-019 rst=1 SHALL immediately (no clock) force IDLE, cmd_ready=1, busy=0, done=0, wr_ready=0, rd_valid=0, rd_data=0, mem_we=0, mem_oe=0, mem_addr=0, mem_wdata=0, cur_addr=0, remaining=0.
REQ-020 rst asserted mid-burst SHALL abort the burst with no further memory write; a new command SHALL be accepted on the first posedge after rst deasserts.

Verification
REQ-021 Write burst: cmd_write=1, addr=0x0010, len=3, wr_valid held, data 0xA0..0xA3 -> mem_we high 4 consecutive cycles, memory[0x10..0x13]=0xA0..0xA3, done pulse the cycle after the 4th beat.
REQ-022 Read burst with backpressure: memory[0x20..0x21]=0x1111,0x2222, read addr=0x20 len=1, rd_ready low 3 cycles -> rd_data=0x1111 held stable with rd_valid=1 throughout, mem_oe=0 while waiting; then 0x2222; one done pulse.
REQ-023 Wrap: write addr=0xFFFF len=1, data 0xBEEF,0xCAFE -> memory[0xFFFF]=0xBEEF, memory[0x0000]=0xCAFE.
REQ-024 Write stall: wr_valid toggles 1,0,0,1 with len=1 -> mem_we only in handshake cycles; exactly 2 writes.
REQ-025 Reset mid-burst: rst asynchronously mid-cycle after beat 2 of a len=7 write -> mem_we=0 before next edge, memory[start+2..] unchanged, busy=0, cmd_ready=1.
REQ-026 Every test SHALL check mem_we&mem_oe never both 1 and cmd_valid ignored while busy=1.
